// File: rtl/mrisc_pkg.sv
// Shared MiniRISC core definitions: datapath width, fetch sequencer states and the NOP word.
package mrisc_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HAND  = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/adder_one.sv
// Constant +1 incrementer (modulo 2^XLEN) built as a half-adder ripple chain.
module adder_one
    import mrisc_pkg::*;
(
    input  logic [XLEN-1:0] incnt,
    output logic [XLEN-1:0] sum
);

    logic [XLEN-1:0] carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
            assign sum[gi] = incnt[gi] ^ carry[gi];
            // The carry out of the top bit is dropped, giving the modulo wrap.
            if (gi < XLEN - 1) begin : g_carry
                assign carry[gi+1] = incnt[gi] & carry[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: fetches one word per request and
// holds it for decode until accepted; execute can redirect the PC at any time.
module pc_fetch_unit
    import mrisc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus1
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] instr_reg, instr_next;
    logic [XLEN-1:0] instr_pc_reg, instr_pc_next;
    logic [XLEN-1:0] pc_plus1_reg, pc_plus1_next;

    adder_one u_adder_one (
        .incnt (pc_reg),
        .sum   (pc_inc)
    );

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        pc_plus1_next = pc_plus1_reg;
        // Handshake outputs decode the state register only, so no input reaches them.
        imem_req      = (state_reg == S_FETCH);
        instr_valid   = (state_reg == S_HAND);

        if (redirect_valid) begin
            // Any data returning this cycle belongs to the abandoned path.
            state_next = S_FETCH;
            pc_next    = redirect_pc;
        end else begin
            case (state_reg)
                S_BOOT: begin
                    state_next = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_next    = imem_rdata;
                        instr_pc_next = pc_reg;
                        pc_plus1_next = pc_inc;
                        pc_next       = pc_inc;
                        state_next    = S_HAND;
                    end
                end
                S_HAND: begin
                    if (instr_ready) begin
                        state_next = S_FETCH;
                    end
                end
                default: begin
                    state_next = S_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_BOOT;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            pc_plus1_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            pc_plus1_reg <= pc_plus1_next;
        end
    end

    assign imem_addr = pc_reg;
    assign instr_out = instr_reg;
    assign instr_pc  = instr_pc_reg;
    assign pc_plus1  = pc_plus1_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios followed by random traffic
// against a behavioural model of the fetch/hand-off protocol.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus1;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .pc_plus1       (pc_plus1)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] link;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: where the program counter is and what the unit is doing.
    logic [31:0] m_pc      = '0;
    bit          booting   = 1'b0;
    bit          holding   = 1'b0;
    bit          known     = 1'b0;
    bit          zero_outs = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // One clock of stimulus: check outputs against the model, drive inputs, advance the model.
    task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit ir, input bit irdy);
        bit fetching;
        @(negedge clk);
        fetching = known && !booting && !holding;
        if (known) begin
            check("imem_req", 32'(imem_req), 32'(fetching));
            check("instr_valid", 32'(instr_valid), 32'(holding));
            check("imem_addr", imem_addr, m_pc);
            if (zero_outs) begin
                check("rst_instr_out", instr_out, 32'h0);
                check("rst_instr_pc", instr_pc, 32'h0);
                check("rst_pc_plus1", pc_plus1, 32'h0);
            end
        end
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rv ? rpc : $urandom();
        imem_ready     = ir;
        imem_rdata     = fetching ? mem_word(m_pc) : $urandom();
        instr_ready    = irdy;

        if (r) begin
            m_pc      = RESET_PC;
            booting   = 1'b1;
            holding   = 1'b0;
            zero_outs = 1'b1;
            known     = 1'b1;
        end else if (rv) begin
            m_pc    = rpc;
            booting = 1'b0;
            holding = 1'b0;
        end else if (booting) begin
            booting = 1'b0;
        end else if (holding) begin
            if (irdy) holding = 1'b0;
        end else if (ir) begin
            exp_q.push_back(exp_t'{pc: m_pc, word: mem_word(m_pc), link: m_pc + 32'd1});
            m_pc      = m_pc + 32'd1;
            holding   = 1'b1;
            zero_outs = 1'b0;
        end
    endtask

    // Monitor: each fresh presentation to decode consumes one scoreboard entry.
    exp_t cur;
    bit   prev_v = 1'b0;
    always @(negedge clk) begin
        if (instr_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_instr", 32'd1, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                check("instr_pc", instr_pc, cur.pc);
                check("instr_out", instr_out, cur.word);
                check("pc_plus1", pc_plus1, cur.link);
                $display("instr pc=%08h word=%08h link=%08h", instr_pc, instr_out, pc_plus1);
            end
        end else if (instr_valid) begin
            check("hold_instr_out", instr_out, cur.word);
            check("hold_instr_pc", instr_pc, cur.pc);
        end
        prev_v = instr_valid;
    end

    initial begin
        logic [31:0] rpc;
        repeat (2) step(1, 0, 0, 0, 0);

        // Zero-wait memory, decode always ready: sequential addresses from RESET_PC.
        repeat (12) step(0, 0, 0, 1, 1);

        // Three wait states at address 5.
        step(0, 1, 32'd5, 0, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);

        // Decode back-pressure for four cycles; memory strobe must be ignored meanwhile.
        repeat (4) step(0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1, 1);

        // Redirect colliding with returning data at address 7.
        step(0, 1, 32'd7, 0, 1);
        step(0, 1, 32'h100, 1, 1);
        repeat (5) step(0, 0, 0, 1, 1);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFF, 0, 1);
        repeat (5) step(0, 0, 0, 1, 1);

        // Reset mid-fetch, then mid-handoff.
        for (int k = 0; k < 10 && (booting || holding); k++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1);
        repeat (4) step(0, 0, 0, 1, 1);
        for (int k = 0; k < 10 && !holding; k++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1, 1);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0:       rpc = $urandom();
                1:       rpc = 32'hFFFF_FFFF;
                2:       rpc = 32'hFFFF_FFFE;
                default: rpc = 32'($urandom_range(0, 255));
            endcase
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0), rpc,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
        end

        repeat (4) step(0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
